// File: rtl/nfc_picc_responder.sv
// ISO 14443-A style card (PICC) responder.
// Receives framed bytes from the demodulator, runs the card state machine
// (REQA/WUPA, anticollision, select, halt) and streams the response bytes to
// the modulator through a valid/ready handshake after a fixed frame delay.
module nfc_picc_responder #(
  parameter logic [31:0] UID      = 32'hDEADBEEF,
  parameter logic [15:0] ATQA     = 16'h0004,
  parameter logic [7:0]  SAK      = 8'h08,
  parameter int unsigned RESP_GAP = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       field_on,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic [3:0] rx_bits,
  input  logic       rx_last,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_last,
  output logic [1:0] picc_state,
  output logic       selected,
  output logic       frame_error
);

  typedef enum logic [1:0] {ENG_RX, ENG_DECODE, ENG_GAP, ENG_TX} eng_t;
  typedef enum logic [1:0] {
    PICC_IDLE   = 2'd0,
    PICC_READY  = 2'd1,
    PICC_ACTIVE = 2'd2,
    PICC_HALT   = 2'd3
  } picc_t;
  typedef enum logic [1:0] {RSP_ATQA, RSP_UID, RSP_SAK} rsp_t;

  localparam logic [7:0] CMD_REQA   = 8'h26;
  localparam logic [7:0] CMD_WUPA   = 8'h52;
  localparam logic [7:0] CMD_SEL_CL = 8'h93;
  localparam logic [7:0] NVB_ANTI   = 8'h20;
  localparam logic [7:0] NVB_SEL    = 8'h70;
  localparam logic [7:0] CMD_HLTA   = 8'h50;
  localparam logic [7:0] UID_BCC    = UID[31:24] ^ UID[23:16] ^ UID[15:8] ^ UID[7:0];
  // Cascade bit is forced clear: this card always has a complete 4-byte UID.
  localparam logic [7:0] SAK_WIRE   = {SAK[7:3], 1'b0, SAK[1:0]};
  localparam logic [7:0] GAP_LD     = 8'(RESP_GAP);
  localparam logic [3:0] FBUF_DEPTH = 4'd9;

  eng_t        eng_q, eng_d;
  picc_t       picc_q;
  rsp_t        rsp_q;
  logic [2:0]  tx_idx_q;
  logic [7:0]  gap_q;
  logic [3:0]  cnt_q;
  logic        ovf_q;
  logic [3:0]  last_bits_q;
  logic        ferr_q;
  logic [7:0]  fbuf [0:8];

  // Decode results, valid while the engine sits in DECODE
  logic        dec_respond;
  logic        dec_err;
  picc_t       dec_picc;
  rsp_t        dec_rsp;
  logic        short_frame;
  logic        full_frame;
  logic        anticoll_hit;
  logic        select_hit;
  logic        hlta_hit;

  logic [7:0]  rsp_byte;
  logic [2:0]  rsp_last_idx;
  logic        rx_store;

  assign short_frame  = (cnt_q == 4'd1) && (last_bits_q == 4'd7);
  assign full_frame   = (last_bits_q == 4'd8);
  assign anticoll_hit = full_frame && (cnt_q == 4'd2) &&
                        (fbuf[0] == CMD_SEL_CL) && (fbuf[1] == NVB_ANTI);
  // CRC bytes 7..8 are accepted as-is; the demodulator front end owns CRC.
  assign select_hit   = full_frame && (cnt_q == 4'd9) &&
                        (fbuf[0] == CMD_SEL_CL) && (fbuf[1] == NVB_SEL) &&
                        (fbuf[2] == UID[31:24]) && (fbuf[3] == UID[23:16]) &&
                        (fbuf[4] == UID[15:8])  && (fbuf[5] == UID[7:0]) &&
                        (fbuf[6] == UID_BCC);
  assign hlta_hit     = full_frame && (cnt_q == 4'd4) &&
                        (fbuf[0] == CMD_HLTA) && (fbuf[1] == 8'h00);

  assign rx_store = field_on && (eng_q == ENG_RX) && rx_valid && (cnt_q < FBUF_DEPTH);

  // Command decode: classify the buffered frame against the current card state
  always_comb begin
    dec_respond = 1'b0;
    dec_err     = 1'b0;
    dec_picc    = picc_q;
    dec_rsp     = RSP_ATQA;
    if (ovf_q) begin
      dec_err = 1'b1;
      if ((picc_q == PICC_READY) || (picc_q == PICC_ACTIVE)) dec_picc = PICC_IDLE;
    end else begin
      case (picc_q)
        PICC_IDLE: begin
          if (short_frame && ((fbuf[0] == CMD_REQA) || (fbuf[0] == CMD_WUPA))) begin
            dec_respond = 1'b1;
            dec_rsp     = RSP_ATQA;
            dec_picc    = PICC_READY;
          end else begin
            dec_err = 1'b1;
          end
        end
        PICC_HALT: begin
          if (short_frame && (fbuf[0] == CMD_WUPA)) begin
            dec_respond = 1'b1;
            dec_rsp     = RSP_ATQA;
            dec_picc    = PICC_READY;
          end else begin
            dec_err = 1'b1;
          end
        end
        PICC_READY: begin
          if (anticoll_hit) begin
            dec_respond = 1'b1;
            dec_rsp     = RSP_UID;
          end else if (select_hit) begin
            dec_respond = 1'b1;
            dec_rsp     = RSP_SAK;
            dec_picc    = PICC_ACTIVE;
          end else begin
            dec_err  = 1'b1;
            dec_picc = PICC_IDLE;
          end
        end
        PICC_ACTIVE: begin
          if (hlta_hit) begin
            dec_picc = PICC_HALT;
          end else begin
            dec_err  = 1'b1;
            dec_picc = PICC_IDLE;
          end
        end
        default: dec_err = 1'b1;
      endcase
    end
  end

  // Response byte selection from the response kind and byte index
  always_comb begin
    rsp_byte     = 8'h00;
    rsp_last_idx = 3'd0;
    case (rsp_q)
      RSP_ATQA: begin
        rsp_last_idx = 3'd1;
        rsp_byte     = (tx_idx_q == 3'd0) ? ATQA[7:0] : ATQA[15:8];
      end
      RSP_UID: begin
        rsp_last_idx = 3'd4;
        case (tx_idx_q)
          3'd0:    rsp_byte = UID[31:24];
          3'd1:    rsp_byte = UID[23:16];
          3'd2:    rsp_byte = UID[15:8];
          3'd3:    rsp_byte = UID[7:0];
          default: rsp_byte = UID_BCC;
        endcase
      end
      RSP_SAK: begin
        rsp_last_idx = 3'd0;
        rsp_byte     = SAK_WIRE;
      end
      default: begin
        rsp_last_idx = 3'd0;
        rsp_byte     = 8'h00;
      end
    endcase
  end

  assign tx_valid    = (eng_q == ENG_TX);
  assign tx_data     = tx_valid ? rsp_byte : 8'h00;
  assign tx_last     = tx_valid && (tx_idx_q == rsp_last_idx);
  assign picc_state  = picc_q;
  assign selected    = (picc_q == PICC_ACTIVE);
  assign frame_error = ferr_q;

  // Engine next-state: receive, decode, frame delay, transmit
  always_comb begin
    eng_d = eng_q;
    case (eng_q)
      ENG_RX:     if (rx_valid && rx_last) eng_d = ENG_DECODE;
      ENG_DECODE: begin
        if (!dec_respond)           eng_d = ENG_RX;
        else if (GAP_LD == 8'd0)    eng_d = ENG_TX;
        else                        eng_d = ENG_GAP;
      end
      ENG_GAP:    if (gap_q <= 8'd1) eng_d = ENG_TX;
      ENG_TX:     if (tx_ready && tx_last) eng_d = ENG_RX;
      default:    eng_d = ENG_RX;
    endcase
    // Loss of field aborts everything, including a handshake this cycle
    if (!field_on) eng_d = ENG_RX;
  end

  // Engine state register
  always_ff @(posedge clk) begin
    if (rst) eng_q <= ENG_RX;
    else     eng_q <= eng_d;
  end

  // Card state, frame bookkeeping, gap timer and transmit index
  always_ff @(posedge clk) begin
    if (rst) begin
      picc_q      <= PICC_IDLE;
      rsp_q       <= RSP_ATQA;
      tx_idx_q    <= 3'd0;
      gap_q       <= 8'd0;
      cnt_q       <= 4'd0;
      ovf_q       <= 1'b0;
      last_bits_q <= 4'd0;
      ferr_q      <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      if (!field_on) begin
        picc_q   <= PICC_IDLE;
        tx_idx_q <= 3'd0;
        gap_q    <= 8'd0;
        cnt_q    <= 4'd0;
        ovf_q    <= 1'b0;
      end else begin
        case (eng_q)
          ENG_RX: begin
            if (rx_valid) begin
              if (cnt_q < FBUF_DEPTH) cnt_q <= cnt_q + 4'd1;
              else                    ovf_q <= 1'b1;
              if (rx_last) last_bits_q <= rx_bits;
            end
          end
          ENG_DECODE: begin
            picc_q   <= dec_picc;
            ferr_q   <= dec_err;
            rsp_q    <= dec_rsp;
            gap_q    <= GAP_LD;
            tx_idx_q <= 3'd0;
            cnt_q    <= 4'd0;
            ovf_q    <= 1'b0;
          end
          ENG_GAP: gap_q <= gap_q - 8'd1;
          ENG_TX: begin
            if (tx_ready) tx_idx_q <= tx_last ? 3'd0 : tx_idx_q + 3'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Frame buffer capture (data only, validity is tracked by cnt_q)
  always_ff @(posedge clk) begin
    if (rx_store) fbuf[cnt_q] <= rx_data;
  end

endmodule

// File: tb/tb_nfc_picc_responder.sv
// Directed bench for nfc_picc_responder with default parameters (RESP_GAP=8).
module tb_nfc_picc_responder;

  logic       clk;
  logic       rst;
  logic       field_on;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [3:0] rx_bits;
  logic       rx_last;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_last;
  logic [1:0] picc_state;
  logic       selected;
  logic       frame_error;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] fr   [0:15];
  logic [7:0] got  [0:15];
  logic       gotl [0:15];
  logic [7:0] uid_rsp [0:4];
  int nb, first_cyc, ferr_seen, stall_viol, last_n;

  nfc_picc_responder dut (
    .clk         (clk),
    .rst         (rst),
    .field_on    (field_on),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_bits     (rx_bits),
    .rx_last     (rx_last),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .tx_last     (tx_last),
    .picc_state  (picc_state),
    .selected    (selected),
    .frame_error (frame_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Present fr[0..n-1] as one frame; last byte carries 'bits' valid bits.
  task automatic send_frame(input int n, input logic [3:0] bits);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = fr[i];
      rx_bits  = (i == n - 1) ? bits : 4'd8;
      rx_last  = (i == n - 1);
      if (i == n - 1) last_n = cyc;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    rx_data  = 8'h00;
    rx_bits  = 4'd0;
  endtask

  // Collect response bytes for up to 'budget' cycles, optionally stalling tx_ready.
  task automatic capture(input bit stall, input int budget);
    int k;
    logic [7:0] prev_d;
    logic prev_l;
    bit prev_stalled;
    nb = 0; first_cyc = -1; ferr_seen = 0; stall_viol = 0;
    k = 0; prev_stalled = 1'b0; prev_d = 8'h00; prev_l = 1'b0;
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      if (frame_error) ferr_seen++;
      if (tx_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (prev_stalled && ((tx_data !== prev_d) || (tx_last !== prev_l))) stall_viol++;
        tx_ready = stall ? ((k % 3) == 2) : 1'b1;
        k++;
        prev_d = tx_data; prev_l = tx_last; prev_stalled = !tx_ready;
        if (tx_ready && nb < 16) begin
          got[nb] = tx_data; gotl[nb] = tx_last; nb++;
          if (tx_last) break;
        end
      end else begin
        prev_stalled = 1'b0;
      end
    end
    tx_ready = 1'b1;
  endtask

  task automatic field_cycle();
    @(negedge clk); field_on = 1'b0;
    @(negedge clk); field_on = 1'b1;
  endtask

  task automatic go_ready();
    field_cycle();
    fr[0] = 8'h26;
    send_frame(1, 4'd7);
    capture(1'b0, 30);
  endtask

  task automatic load_select(input logic [7:0] bcc);
    fr[0] = 8'h93; fr[1] = 8'h70; fr[2] = 8'hDE; fr[3] = 8'hAD; fr[4] = 8'hBE;
    fr[5] = 8'hEF; fr[6] = bcc;   fr[7] = 8'h00; fr[8] = 8'h00;
  endtask

  task automatic test_reset();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
    checks++; if (tx_last !== 1'b0) begin errors++; $display("FAIL rst_tx_last: got %b want 0", tx_last); end
    checks++; if (picc_state !== 2'd0) begin errors++; $display("FAIL rst_picc_state: got %0d want 0", picc_state); end
    checks++; if (selected !== 1'b0) begin errors++; $display("FAIL rst_selected: got %b want 0", selected); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL rst_frame_error: got %b want 0", frame_error); end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL post_rst_tx_valid: got %b want 0", tx_valid); end
    checks++; if (picc_state !== 2'd0) begin errors++; $display("FAIL post_rst_state: got %0d want 0", picc_state); end
  endtask

  task automatic test_full_select();
    field_cycle();
    fr[0] = 8'h26;
    send_frame(1, 4'd7);
    capture(1'b0, 30);
    checks++; if (nb !== 2) begin errors++; $display("FAIL reqa_count: got %0d want 2", nb); end
    checks++; if (got[0] !== 8'h04) begin errors++; $display("FAIL reqa_b0: got %h want 04", got[0]); end
    checks++; if (got[1] !== 8'h00) begin errors++; $display("FAIL reqa_b1: got %h want 00", got[1]); end
    checks++; if (gotl[0] !== 1'b0 || gotl[1] !== 1'b1) begin errors++; $display("FAIL reqa_last: got %b%b want 01", gotl[0], gotl[1]); end
    checks++; if (first_cyc !== last_n + 10) begin errors++; $display("FAIL reqa_latency: got %0d want %0d", first_cyc - last_n, 10); end
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reqa_drop: got %b want 0", tx_valid); end
    checks++; if (picc_state !== 2'd1) begin errors++; $display("FAIL reqa_state: got %0d want 1", picc_state); end

    fr[0] = 8'h93; fr[1] = 8'h20;
    send_frame(2, 4'd8);
    capture(1'b0, 30);
    checks++; if (nb !== 5) begin errors++; $display("FAIL anticoll_count: got %0d want 5", nb); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (got[i] !== uid_rsp[i]) begin errors++; $display("FAIL anticoll_b%0d: got %h want %h", i, got[i], uid_rsp[i]); end
    end
    checks++; if (gotl[4] !== 1'b1) begin errors++; $display("FAIL anticoll_last: got %b want 1", gotl[4]); end
    checks++; if (picc_state !== 2'd1) begin errors++; $display("FAIL anticoll_state: got %0d want 1", picc_state); end

    load_select(8'h22);
    send_frame(9, 4'd8);
    capture(1'b0, 30);
    checks++; if (nb !== 1) begin errors++; $display("FAIL select_count: got %0d want 1", nb); end
    checks++; if (got[0] !== 8'h08 || gotl[0] !== 1'b1) begin errors++; $display("FAIL select_sak: got %h/%b want 08/1", got[0], gotl[0]); end
    @(negedge clk);
    checks++; if (selected !== 1'b1) begin errors++; $display("FAIL select_selected: got %b want 1", selected); end
    checks++; if (picc_state !== 2'd2) begin errors++; $display("FAIL select_state: got %0d want 2", picc_state); end
  endtask

  task automatic test_bad_select();
    go_ready();
    load_select(8'h23);
    send_frame(9, 4'd8);
    capture(1'b0, 20);
    checks++; if (nb !== 0 || first_cyc !== -1) begin errors++; $display("FAIL badsel_resp: got %0d bytes want 0", nb); end
    checks++; if (ferr_seen !== 1) begin errors++; $display("FAIL badsel_ferr: got %0d cycles want 1", ferr_seen); end
    checks++; if (picc_state !== 2'd0) begin errors++; $display("FAIL badsel_state: got %0d want 0", picc_state); end
  endtask

  task automatic test_halt_wake();
    go_ready();
    load_select(8'h22);
    send_frame(9, 4'd8);
    capture(1'b0, 30);
    checks++; if (picc_state !== 2'd2) begin errors++; $display("FAIL halt_pre_state: got %0d want 2", picc_state); end
    fr[0] = 8'h50; fr[1] = 8'h00; fr[2] = 8'h00; fr[3] = 8'h00;
    send_frame(4, 4'd8);
    capture(1'b0, 20);
    checks++; if (nb !== 0) begin errors++; $display("FAIL hlta_resp: got %0d bytes want 0", nb); end
    checks++; if (ferr_seen !== 0) begin errors++; $display("FAIL hlta_ferr: got %0d want 0", ferr_seen); end
    checks++; if (picc_state !== 2'd3 || selected !== 1'b0) begin errors++; $display("FAIL hlta_state: got %0d/%b want 3/0", picc_state, selected); end
    fr[0] = 8'h26;
    send_frame(1, 4'd7);
    capture(1'b0, 20);
    checks++; if (nb !== 0) begin errors++; $display("FAIL halt_reqa_resp: got %0d bytes want 0", nb); end
    checks++; if (ferr_seen !== 1) begin errors++; $display("FAIL halt_reqa_ferr: got %0d want 1", ferr_seen); end
    checks++; if (picc_state !== 2'd3) begin errors++; $display("FAIL halt_reqa_state: got %0d want 3", picc_state); end
    fr[0] = 8'h52;
    send_frame(1, 4'd7);
    capture(1'b0, 30);
    checks++; if (nb !== 2 || got[0] !== 8'h04 || got[1] !== 8'h00) begin errors++; $display("FAIL wupa_resp: got %0d bytes %h %h want 2 bytes 04 00", nb, got[0], got[1]); end
    checks++; if (picc_state !== 2'd1) begin errors++; $display("FAIL wupa_state: got %0d want 1", picc_state); end
  endtask

  task automatic test_backpressure();
    go_ready();
    fr[0] = 8'h93; fr[1] = 8'h20;
    send_frame(2, 4'd8);
    capture(1'b1, 60);
    checks++; if (nb !== 5) begin errors++; $display("FAIL bp_count: got %0d want 5", nb); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (got[i] !== uid_rsp[i]) begin errors++; $display("FAIL bp_b%0d: got %h want %h", i, got[i], uid_rsp[i]); end
    end
    checks++; if (stall_viol !== 0) begin errors++; $display("FAIL bp_stable: got %0d changes want 0", stall_viol); end
    checks++; if (gotl[4] !== 1'b1) begin errors++; $display("FAIL bp_last: got %b want 1", gotl[4]); end
  endtask

  task automatic test_field_drop();
    int seen;
    bit dropped;
    go_ready();
    fr[0] = 8'h93; fr[1] = 8'h20;
    send_frame(2, 4'd8);
    seen = 0; dropped = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (tx_valid) begin
        if (seen == 2) begin
          checks++; if (tx_data !== 8'hBE) begin errors++; $display("FAIL drop_b2: got %h want BE", tx_data); end
          field_on = 1'b0; dropped = 1'b1;
          break;
        end
        seen++;
      end
    end
    checks++; if (!dropped) begin errors++; $display("FAIL drop_timeout: got %0d bytes want 3", seen); end
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL drop_tx_valid: got %b want 0", tx_valid); end
    checks++; if (picc_state !== 2'd0) begin errors++; $display("FAIL drop_state: got %0d want 0", picc_state); end
    field_on = 1'b1;
  endtask

  task automatic test_overflow();
    go_ready();
    for (int i = 0; i < 10; i++) fr[i] = 8'h93 + 8'(i);
    send_frame(10, 4'd8);
    capture(1'b0, 20);
    checks++; if (nb !== 0) begin errors++; $display("FAIL ovf_resp: got %0d bytes want 0", nb); end
    checks++; if (ferr_seen !== 1) begin errors++; $display("FAIL ovf_ferr: got %0d want 1", ferr_seen); end
    checks++; if (picc_state !== 2'd0) begin errors++; $display("FAIL ovf_state: got %0d want 0", picc_state); end
    fr[0] = 8'h26;
    send_frame(1, 4'd7);
    capture(1'b0, 30);
    checks++; if (nb !== 2 || got[0] !== 8'h04 || got[1] !== 8'h00) begin errors++; $display("FAIL ovf_reqa: got %0d bytes %h %h want 2 bytes 04 00", nb, got[0], got[1]); end
    checks++; if (picc_state !== 2'd1) begin errors++; $display("FAIL ovf_reqa_state: got %0d want 1", picc_state); end
  endtask

  task automatic test_reset_mid();
    int seen;
    bit hit;
    field_cycle();
    fr[0] = 8'h26;
    send_frame(1, 4'd7);
    hit = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (tx_valid) begin rst = 1'b1; hit = 1'b1; break; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL rstmid_timeout: got no tx_valid want one"); end
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0 || picc_state !== 2'd0) begin errors++; $display("FAIL rstmid_abort: got %b/%0d want 0/0", tx_valid, picc_state); end
    rst = 1'b0;
    seen = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (tx_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_quiet: got %0d valid cycles want 0", seen); end
  endtask

  initial begin
    rst = 1'b1; field_on = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    rx_bits = 4'd0; rx_last = 1'b0; tx_ready = 1'b1;
    uid_rsp = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    repeat (3) @(negedge clk);
    test_reset();
    test_full_select();
    test_bad_select();
    test_halt_wake();
    test_backpressure();
    test_field_drop();
    test_overflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
